// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_AUX = 1'b1;

  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - cycle counter that flags a transfer stuck waiting for ack
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  // TIMEOUT of zero disables expiry entirely; the counter still runs harmlessly
  assign w_at_last = (TIMEOUT != 0) && (r_cnt == LAST);
  assign o_expired = w_at_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter (CPU + aux) for the single memory port
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_load,
  input  logic              i_cpu_store,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ready,
  input  logic              i_aux_req,
  input  logic              i_aux_we,
  input  logic [ADDR_W-1:0] i_aux_addr,
  input  logic [DATA_W-1:0] i_aux_wdata,
  output logic [DATA_W-1:0] o_aux_rdata,
  output logic              o_aux_ready,
  output logic              o_aux_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_owner,
  output logic              o_busy,
  output logic              o_timeout_flag
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_e            r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_aux_rdata;
  logic              r_cpu_ready;
  logic              r_aux_ready;
  logic              r_aux_err;
  logic              r_owner;
  logic              r_timeout_flag;
  logic [SW-1:0]     r_starve_cnt;

  logic w_cpu_rq;
  logic w_any_rq;
  logic w_grant_aux;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_expired;

  assign w_cpu_rq    = i_cpu_load | i_cpu_store;
  assign w_any_rq    = w_cpu_rq | i_aux_req;
  // Aux wins when it is alone, or when the CPU has used up its starvation budget
  assign w_grant_aux = i_aux_req & (~w_cpu_rq | (r_starve_cnt == STARVE_MAX));

  assign w_wd_clr = (r_state != S_GRANT);
  assign w_wd_en  = (r_state == S_GRANT) && !i_mem_ack;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expired(w_wd_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_cpu_rdata    <= '0;
      r_aux_rdata    <= '0;
      r_cpu_ready    <= 1'b0;
      r_aux_ready    <= 1'b0;
      r_aux_err      <= 1'b0;
      r_owner        <= OWNER_CPU;
      r_timeout_flag <= 1'b0;
      r_starve_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_rq) begin
            r_mem_req <= 1'b1;
            r_state   <= S_GRANT;
            if (w_grant_aux) begin
              r_owner      <= OWNER_AUX;
              r_mem_we     <= i_aux_we;
              r_mem_addr   <= i_aux_addr;
              r_mem_wdata  <= i_aux_wdata;
              r_starve_cnt <= '0;
            end else begin
              r_owner     <= OWNER_CPU;
              r_mem_we    <= i_cpu_store;
              r_mem_addr  <= i_cpu_addr;
              r_mem_wdata <= i_cpu_wdata;
              if (!i_aux_req) begin
                r_starve_cnt <= '0;
              end else if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
              end
            end
          end
        end

        S_GRANT: begin
          if (i_mem_ack) begin
            r_mem_req   <= 1'b0;
            r_state     <= S_DONE;
            r_cpu_ready <= (r_owner == OWNER_CPU);
            r_aux_ready <= (r_owner == OWNER_AUX);
            if (!r_mem_we) begin
              if (r_owner == OWNER_AUX) r_aux_rdata <= i_mem_rdata;
              else                      r_cpu_rdata <= i_mem_rdata;
            end
          end else if (w_wd_expired) begin
            // Abort: the owner still gets its completion pulse, flagged as failed
            r_mem_req      <= 1'b0;
            r_state        <= S_DONE;
            r_timeout_flag <= 1'b1;
            r_cpu_ready    <= (r_owner == OWNER_CPU);
            r_aux_ready    <= (r_owner == OWNER_AUX);
            r_aux_err      <= (r_owner == OWNER_AUX);
            if (r_owner == OWNER_AUX) r_aux_rdata <= DATA_W'(TIMEOUT_DATA);
            else                      r_cpu_rdata <= DATA_W'(TIMEOUT_DATA);
          end
        end

        S_DONE: begin
          r_cpu_ready <= 1'b0;
          r_aux_ready <= 1'b0;
          r_aux_err   <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_mem_req   <= 1'b0;
          r_cpu_ready <= 1'b0;
          r_aux_ready <= 1'b0;
          r_aux_err   <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cpu_rdata    = r_cpu_rdata;
  assign o_cpu_ready    = r_cpu_ready;
  assign o_aux_rdata    = r_aux_rdata;
  assign o_aux_ready    = r_aux_ready;
  assign o_aux_err      = r_aux_err;
  assign o_mem_req      = r_mem_req;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_owner        = r_owner;
  assign o_busy         = (r_state != S_IDLE);
  assign o_timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed vector bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_load, cpu_store;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        aux_req, aux_we;
  logic [23:0] aux_addr;
  logic [15:0] aux_wdata;
  logic [15:0] aux_rdata;
  logic        aux_ready, aux_err;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        owner, busy, timeout_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(24), .DATA_W(16), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_load(cpu_load), .i_cpu_store(cpu_store),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready),
    .i_aux_req(aux_req), .i_aux_we(aux_we),
    .i_aux_addr(aux_addr), .i_aux_wdata(aux_wdata),
    .o_aux_rdata(aux_rdata), .o_aux_ready(aux_ready), .o_aux_err(aux_err),
    .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_owner(owner), .o_busy(busy), .o_timeout_flag(timeout_flag)
  );

  typedef struct {
    logic        aux;
    logic        load;
    logic        store;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    int          dly;
    logic [15:0] mdata;
    logic        exp_we;
    int          exp_n;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drop_requests();
    cpu_load  = 1'b0;
    cpu_store = 1'b0;
    aux_req   = 1'b0;
    aux_we    = 1'b0;
    mem_ack   = 1'b0;
  endtask

  // dly = cycles of mem_req before ack is raised; negative means never ack
  task automatic run_vec(input int i);
    vec_t v;
    int   n;
    int   k;
    logic got;
    v = vecs[i];
    @(negedge clk);
    if (v.aux) begin
      aux_req = 1'b1; aux_we = v.we; aux_addr = v.addr; aux_wdata = v.wdata;
    end else begin
      cpu_load = v.load; cpu_store = v.store; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    n = 0; k = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_ready || aux_ready) begin
        got = 1'b1;
        check($sformatf("v%0d latency", i), n, v.exp_n);
        check($sformatf("v%0d owner", i), {31'd0, owner}, {31'd0, v.aux});
        check($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d aux_err", i), {31'd0, aux_err}, {31'd0, v.exp_err});
        if (v.aux) begin
          check($sformatf("v%0d readies", i), {30'd0, cpu_ready, aux_ready}, 32'd1);
          check($sformatf("v%0d aux_rdata", i), {16'd0, aux_rdata}, {16'd0, v.exp_rd});
        end else begin
          check($sformatf("v%0d readies", i), {30'd0, cpu_ready, aux_ready}, 32'd2);
          check($sformatf("v%0d cpu_rdata", i), {16'd0, cpu_rdata}, {16'd0, v.exp_rd});
        end
        drop_requests();
      end else if (mem_req) begin
        k++;
        if (k == 1) begin
          check($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, v.exp_we});
          check($sformatf("v%0d mem_addr", i), {8'd0, mem_addr}, {8'd0, v.addr});
          if (v.exp_we)
            check($sformatf("v%0d mem_wdata", i), {16'd0, mem_wdata}, {16'd0, v.wdata});
        end
        if (v.dly >= 0 && k >= v.dly + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = v.mdata;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
    if (!got) check($sformatf("v%0d ready seen", i), 32'd0, 32'd1);
    drop_requests();
    @(negedge clk);
    check($sformatf("v%0d idle after", i), {30'd0, busy, cpu_ready | aux_ready}, 32'd0);
  endtask

  initial begin
    int n;
    int cnt;
    logic got;
    logic exp_own[10];

    //            aux load store we  addr        wdata     dly mdata     ewe n  exp_rd    err
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h01_0010, 16'h0000, 1,  16'hBEEF, 1'b0, 3, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 24'hFF_0002, 16'h1234, 0,  16'hDEAD, 1'b1, 2, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h00_0100, 16'h0000, 0,  16'h5A5A, 1'b0, 2, 16'h5A5A, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 24'h12_3456, 16'hA5A5, 2,  16'h7777, 1'b1, 4, 16'hBEEF, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h00_0200, 16'h0000, -1, 16'h0000, 1'b0, 9, 16'hFFFF, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h00_0004, 16'h0000, 0,  16'h0001, 1'b0, 2, 16'h0001, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h00_00F0, 16'h0F0F, 0,  16'h3333, 1'b1, 2, 16'h0001, 1'b0};

    // Reset with both requesters active
    rst_n = 1'b0;
    cpu_load = 1'b1; cpu_store = 1'b0; cpu_addr = 24'h01_0010; cpu_wdata = 16'h5555;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 24'hFF_0002; aux_wdata = 16'hAAAA;
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    repeat (3) begin
      @(negedge clk);
      check("reset ctrl", {24'd0, mem_req, mem_we, cpu_ready, aux_ready, aux_err, owner, busy, timeout_flag}, 32'd0);
    end
    check("reset mem_addr", {8'd0, mem_addr}, 32'd0);
    check("reset mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("reset rdata", {cpu_rdata, aux_rdata}, 32'd0);
    drop_requests();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i);
    check("timeout_flag sticky", {31'd0, timeout_flag}, 32'd1);

    // Continuous contention: four CPU grants then one aux grant, repeating
    exp_own = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    cpu_load = 1'b1; cpu_addr = 24'h00_1000;
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 24'h00_2000;
    mem_rdata = 16'h4242;
    cnt = 0; n = 0;
    while (cnt < 10 && n < 80) begin
      @(negedge clk);
      n++;
      check("ready overlap", {31'd0, cpu_ready & aux_ready}, 32'd0);
      if (cpu_ready || aux_ready) begin
        check($sformatf("starve grant %0d", cnt), {31'd0, aux_ready}, {31'd0, exp_own[cnt]});
        cnt++;
        mem_ack = 1'b0;
      end else begin
        mem_ack = mem_req;
      end
    end
    check("starve grants done", cnt, 10);
    drop_requests();
    repeat (2) @(negedge clk);

    // Asynchronous reset while a CPU transfer is waiting in GRANT
    cpu_load = 1'b1; cpu_addr = 24'h00_0ABC;
    @(negedge clk);
    check("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async drop mem_req", {30'd0, mem_req, busy}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("no ready in reset", {31'd0, cpu_ready}, 32'd0);
    end
    check("reset clears flag", {31'd0, timeout_flag}, 32'd0);
    rst_n = 1'b1;
    mem_rdata = 16'hC0DE;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (cpu_ready) begin
        got = 1'b1;
        mem_ack = 1'b0;
      end else begin
        mem_ack = mem_req;
      end
    end
    check("reserve ready", {31'd0, got}, 32'd1);
    check("reserve latency", n, 2);
    check("reserve rdata", {16'd0, cpu_rdata}, 32'h0000_C0DE);
    drop_requests();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
